// File: rtl/fpga_cfg_pkg.sv
// Shared FPGA configuration constants and types for the QMC engine datapath.
package fpga_cfg_pkg;

    localparam int unsigned FP_WIDTH          = 32;
    localparam int unsigned SQRT_N_REQ        = 4;
    localparam int unsigned SQRT_MAX_INFLIGHT = 8;
    localparam int unsigned SQRT_ID_W         = $clog2(SQRT_N_REQ);

    typedef logic [SQRT_ID_W-1:0] sqrt_req_id_t;

endpackage

// File: rtl/fx_sqrt_share_arb_tag_fifo.sv
// In-order tag FIFO: records the requester ID of each issued fxSqrt operation.
module sqrt_tag_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DW    = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DW-1:0]                din,
    output logic [DW-1:0]                dout,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fx_sqrt_share_arb.sv
// Shares one fxSqrt pipeline between N_REQ requesters: round-robin issue,
// in-order tag tracking, and per-requester steering of returned results.
module fx_sqrt_share_arb
    import fpga_cfg_pkg::*;
#(
    parameter int unsigned N_REQ        = SQRT_N_REQ,
    parameter int unsigned WIDTH        = FP_WIDTH,
    parameter int unsigned MAX_INFLIGHT = SQRT_MAX_INFLIGHT,
    localparam int unsigned ID_W        = $clog2(N_REQ),
    localparam int unsigned CNT_W       = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   sq_valid,
    input  logic                   sq_ready,
    output logic [WIDTH-1:0]       sq_a,
    input  logic                   sq_rvalid,
    output logic                   sq_rready,
    input  logic [WIDTH-1:0]       sq_result,
    output logic [CNT_W-1:0]       inflight,
    output logic                   err_orphan
);

    logic [ID_W-1:0] rr_q, rr_d;
    logic [ID_W-1:0] winner;
    logic            found;
    int unsigned     idx;
    logic            can_issue;
    logic            issue;
    logic [ID_W-1:0] tag_head;
    logic            fifo_empty;
    logic            fifo_full;
    logic            fifo_pop;
    logic            err_orphan_q, err_orphan_d;

    // Rotating-priority search starting at rr_q.
    always_comb begin
        winner = rr_q;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req_valid[ID_W'(idx)]) begin
                winner = ID_W'(idx);
                found  = 1'b1;
            end
        end
    end

    // Issue side; every handshake output is held low during reset.
    always_comb begin
        can_issue = rst_n && sq_ready && (inflight < CNT_W'(MAX_INFLIGHT));
        sq_valid  = can_issue && found;
        issue     = sq_valid;
        req_ready = '0;
        sq_a      = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == winner) begin
                sq_a = req_data[i*WIDTH +: WIDTH];
            end
        end
        if (issue) begin
            req_ready = N_REQ'(1) << winner;
        end
        rr_d = rr_q;
        if (issue) begin
            rr_d = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
        end
    end

    // Return side: a beat with no tag is drained and flagged as an orphan.
    always_comb begin
        rsp_data     = sq_result;
        rsp_valid    = '0;
        sq_rready    = 1'b0;
        if (rst_n) begin
            if (fifo_empty) begin
                sq_rready = sq_rvalid;
            end else begin
                sq_rready = rsp_ready[tag_head];
                if (sq_rvalid) begin
                    rsp_valid = N_REQ'(1) << tag_head;
                end
            end
        end
        fifo_pop     = sq_rvalid && sq_rready && !fifo_empty;
        err_orphan_d = err_orphan_q || (sq_rvalid && fifo_empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q         <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            rr_q         <= rr_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    sqrt_tag_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .DW    (ID_W)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (issue),
        .pop   (fifo_pop),
        .din   (winner),
        .dout  (tag_head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (inflight)
    );

    assign err_orphan = err_orphan_q;

    logic unused_ok;
    assign unused_ok = fifo_full;

endmodule

// File: tb/tb_fx_sqrt_share_arb.sv
// Directed bench for fx_sqrt_share_arb with a fixed-latency behavioural fxSqrt model.
module tb_fx_sqrt_share_arb;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 32;
    localparam int unsigned MI = 8;
    localparam int unsigned CW = $clog2(MI + 1);
    localparam int          L  = 10;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_data;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [W-1:0]    rsp_data;
    logic            sq_valid;
    logic            sq_ready;
    logic [W-1:0]    sq_a;
    logic            sq_rvalid;
    logic            sq_rready;
    logic [W-1:0]    sq_result;
    logic [CW-1:0]   inflight;
    logic            err_orphan;

    fx_sqrt_share_arb #(.N_REQ(N), .WIDTH(W), .MAX_INFLIGHT(MI)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .sq_valid(sq_valid), .sq_ready(sq_ready), .sq_a(sq_a),
        .sq_rvalid(sq_rvalid), .sq_rready(sq_rready), .sq_result(sq_result),
        .inflight(inflight), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Requester operand buffers.
    logic [W-1:0] lbuf [N][16];
    int           lhead [N];
    int           ltail [N];

    // fxSqrt model: result queue with due cycles.
    logic [W-1:0] mq_val [$];
    int           mq_due [$];
    int           cyc = 0;
    bit           model_rv = 0;
    bit           force_rv = 0;
    bit           stall_en = 0;

    // Observation logs.
    int           iss_lane [$];
    int           ret_lane [$];
    logic [W-1:0] ret_data [$];
    logic [N-1:0] ret_oh [$];

    // Signals sampled just before the last clock edge.
    bit           s_iss, s_ret, s_mrv, s_sq_valid, s_sq_rready;
    int           s_infl;
    logic [N-1:0] s_req_ready, s_rsp_valid;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] isqrt_q16(input logic [W-1:0] a);
        longint unsigned x, r, t;
        x = {32'd0, a} << 16;
        r = 0;
        for (int b = 31; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= x) r = t;
        end
        return W'(r);
    endfunction

    function automatic int oh2i(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (lhead[i] != ltail[i]);
            req_data[i*W +: W] = req_valid[i] ? lbuf[i][lhead[i]] : '0;
        end
    endtask

    task automatic load(input int lane, input logic [W-1:0] v);
        lbuf[lane][ltail[lane]] = v;
        ltail[lane]++;
        drive_reqs();
    endtask

    task automatic clear_lanes();
        for (int i = 0; i < N; i++) begin
            lhead[i] = 0;
            ltail[i] = 0;
        end
        drive_reqs();
    endtask

    task automatic tick();
        logic [W-1:0] a_s, res_s;
        int           l;
        #2;
        s_sq_valid  = sq_valid;
        s_iss       = sq_valid && sq_ready;
        s_ret       = sq_rvalid && sq_rready;
        s_mrv       = model_rv;
        s_req_ready = req_ready;
        s_rsp_valid = rsp_valid;
        s_sq_rready = sq_rready;
        s_infl      = int'(inflight);
        a_s         = sq_a;
        res_s       = sq_result;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mq_val.delete();
            mq_due.delete();
        end else begin
            if (s_iss) begin
                mq_val.push_back(isqrt_q16(a_s));
                mq_due.push_back(cyc + L);
                l = oh2i(s_req_ready);
                iss_lane.push_back(l);
                if (l >= 0) lhead[l]++;
            end
            if (s_ret) begin
                if (s_rsp_valid != '0) begin
                    ret_lane.push_back(oh2i(s_rsp_valid));
                    ret_data.push_back(res_s);
                    ret_oh.push_back(s_rsp_valid);
                end
                if (s_mrv) begin
                    void'(mq_val.pop_front());
                    void'(mq_due.pop_front());
                end
            end
        end
        cyc++;
        model_rv  = (mq_val.size() > 0) && (mq_due[0] <= cyc);
        sq_rvalid = model_rv || force_rv;
        sq_result = model_rv ? mq_val[0] : '0;
        sq_ready  = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        drive_reqs();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic run_until_rets(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (ret_lane.size() < n && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_ret_count"}, 64'(ret_lane.size()), 64'(n));
    endtask

    task automatic run_until_iss(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (iss_lane.size() < n && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_iss_count"}, 64'(iss_lane.size()), 64'(n));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_lanes();
        iss_lane.delete();
        ret_lane.delete();
        ret_data.delete();
        ret_oh.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [W-1:0] sq16(input int v);
        return W'(v * v) << 16;
    endfunction

    initial begin
        rst_n     = 1'b0;
        sq_ready  = 1'b1;
        sq_rvalid = 1'b0;
        sq_result = '0;
        rsp_ready = '0;
        req_valid = '0;
        req_data  = '0;
        clear_lanes();
        load(1, 32'h0001_0000);
        #3;
        check("rst_sq_valid",   64'(sq_valid),   64'd0);
        check("rst_req_ready",  64'(req_ready),  64'd0);
        check("rst_rsp_valid",  64'(rsp_valid),  64'd0);
        check("rst_sq_rready",  64'(sq_rready),  64'd0);
        check("rst_inflight",   64'(inflight),   64'd0);
        check("rst_err_orphan", 64'(err_orphan), 64'd0);

        // 1: single lane 2, sqrt(4.0) = 2.0
        do_reset();
        stall_en  = 1;
        rsp_ready = '1;
        load(2, 32'h0004_0000);
        run_until_rets(1, 60, "t1");
        run(2);
        check("t1_iss_total", 64'(iss_lane.size()), 64'd1);
        if (ret_lane.size() > 0) begin
            check("t1_iss_lane", 64'(iss_lane[0]), 64'd2);
            check("t1_rsp_valid", 64'(ret_oh[0]), 64'b0100);
            check("t1_rsp_data", 64'(ret_data[0]), 64'h0002_0000);
        end
        check("t1_inflight", 64'(inflight), 64'd0);

        // 2: all lanes valid from reset, round-robin order
        do_reset();
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < N; i++) load(i, sq16(i + 1));
        run_until_rets(16, 400, "t2");
        for (int k = 0; k < 16 && k < ret_lane.size(); k++) begin
            check($sformatf("t2_iss_lane%0d", k), 64'(iss_lane[k]), 64'(k % 4));
            check($sformatf("t2_ret_lane%0d", k), 64'(ret_lane[k]), 64'(k % 4));
            check($sformatf("t2_ret_data%0d", k), 64'(ret_data[k]), 64'((k % 4 + 1) << 16));
        end

        // 3: backpressure fills the tag FIFO to MAX_INFLIGHT
        do_reset();
        stall_en  = 0;
        rsp_ready = '0;
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < N; i++) load(i, sq16(i + 1));
        run(40);
        check("t3_iss_at_full", 64'(iss_lane.size()), 64'd8);
        check("t3_inflight_full", 64'(inflight), 64'd8);
        check("t3_req_ready_full", 64'(s_req_ready), 64'd0);
        check("t3_sq_valid_full", 64'(s_sq_valid), 64'd0);
        check("t3_rsp_valid_head", 64'(s_rsp_valid), 64'b0001);
        check("t3_sq_rready_held", 64'(s_sq_rready), 64'd0);
        rsp_ready = '1;
        run_until_rets(12, 300, "t3");
        for (int k = 0; k < 12 && k < ret_lane.size(); k++) begin
            check($sformatf("t3_ret_lane%0d", k), 64'(ret_lane[k]), 64'(k % 4));
            check($sformatf("t3_ret_data%0d", k), 64'(ret_data[k]), 64'((k % 4 + 1) << 16));
        end
        run(2);
        check("t3_inflight_drained", 64'(inflight), 64'd0);

        // 4: issue order lanes 3,1,0,2 with 1.0, 9.0, 16.0, 0.25
        do_reset();
        stall_en  = 1;
        rsp_ready = '1;
        load(3, 32'h0001_0000);
        run_until_iss(1, 40, "t4a");
        load(1, 32'h0009_0000);
        run_until_iss(2, 40, "t4b");
        load(0, 32'h0010_0000);
        run_until_iss(3, 40, "t4c");
        load(2, 32'h0000_4000);
        run_until_iss(4, 40, "t4d");
        run_until_rets(4, 100, "t4");
        if (ret_lane.size() >= 4) begin
            check("t4_iss0", 64'(iss_lane[0]), 64'd3);
            check("t4_iss1", 64'(iss_lane[1]), 64'd1);
            check("t4_iss2", 64'(iss_lane[2]), 64'd0);
            check("t4_iss3", 64'(iss_lane[3]), 64'd2);
            check("t4_lane0", 64'(ret_lane[0]), 64'd3);
            check("t4_lane1", 64'(ret_lane[1]), 64'd1);
            check("t4_lane2", 64'(ret_lane[2]), 64'd0);
            check("t4_lane3", 64'(ret_lane[3]), 64'd2);
            check("t4_data0", 64'(ret_data[0]), 64'h0001_0000);
            check("t4_data1", 64'(ret_data[1]), 64'h0003_0000);
            check("t4_data2", 64'(ret_data[2]), 64'h0004_0000);
            check("t4_data3", 64'(ret_data[3]), 64'h0000_8000);
        end

        // 5a: simultaneous push and pop at inflight=1
        do_reset();
        stall_en  = 0;
        rsp_ready = '0;
        load(0, 32'h0001_0000);
        run(15);
        check("t5a_inflight_pre", 64'(inflight), 64'd1);
        load(1, 32'h0004_0000);
        rsp_ready = '1;
        tick();
        check("t5a_push", 64'(s_iss), 64'd1);
        check("t5a_pop", 64'(s_ret), 64'd1);
        check("t5a_infl_before", 64'(s_infl), 64'd1);
        check("t5a_infl_after", 64'(inflight), 64'd1);
        run_until_rets(2, 40, "t5a");
        run(5);
        check("t5a_no_dup", 64'(ret_lane.size()), 64'd2);
        check("t5a_inflight_end", 64'(inflight), 64'd0);
        if (ret_lane.size() >= 2) begin
            check("t5a_data0", 64'(ret_data[0]), 64'h0001_0000);
            check("t5a_data1", 64'(ret_data[1]), 64'h0002_0000);
            check("t5a_lane1", 64'(ret_lane[1]), 64'd1);
        end

        // 5b: push+pop at inflight=7, then pop-only at full
        do_reset();
        rsp_ready = '0;
        for (int k = 0; k < 7; k++) load(k % 4, sq16(k + 1));
        run(25);
        check("t5b_inflight7", 64'(inflight), 64'd7);
        load(3, sq16(8));
        rsp_ready = '1;
        tick();
        rsp_ready = '0;
        check("t5b_push", 64'(s_iss), 64'd1);
        check("t5b_pop", 64'(s_ret), 64'd1);
        check("t5b_infl_after", 64'(inflight), 64'd7);
        load(0, sq16(9));
        run(20);
        check("t5b_inflight8", 64'(inflight), 64'd8);
        load(1, sq16(10));
        run(2);
        check("t5b_blocked_at_full", 64'(s_req_ready), 64'd0);
        rsp_ready = '1;
        tick();
        check("t5b_full_no_push", 64'(s_iss), 64'd0);
        check("t5b_full_pop", 64'(s_ret), 64'd1);
        check("t5b_full_after", 64'(inflight), 64'd7);
        run_until_rets(10, 200, "t5b");
        for (int k = 0; k < 10 && k < ret_lane.size(); k++) begin
            check($sformatf("t5b_data%0d", k), 64'(ret_data[k]), 64'((k + 1) << 16));
            check($sformatf("t5b_lane%0d", k), 64'(ret_lane[k]),
                  64'((k < 7) ? (k % 4) : ((k == 7) ? 3 : ((k == 8) ? 0 : 1))));
        end

        // 6: orphan result, then reset in the middle of a burst
        do_reset();
        rsp_ready = '1;
        force_rv  = 1;
        sq_rvalid = 1'b1;
        tick();
        check("t6_orphan_drain", 64'(s_sq_rready), 64'd1);
        check("t6_orphan_no_rsp", 64'(s_rsp_valid), 64'd0);
        force_rv  = 0;
        sq_rvalid = 1'b0;
        tick();
        check("t6_err_set", 64'(err_orphan), 64'd1);
        run(5);
        check("t6_err_sticky", 64'(err_orphan), 64'd1);
        check("t6_inflight0", 64'(inflight), 64'd0);
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < N; i++) load(i, sq16(i + 1));
        run(12);
        rst_n = 1'b0;
        #1;
        check("t6_rst_sq_valid",  64'(sq_valid),   64'd0);
        check("t6_rst_req_ready", 64'(req_ready),  64'd0);
        check("t6_rst_rsp_valid", 64'(rsp_valid),  64'd0);
        check("t6_rst_sq_rready", 64'(sq_rready),  64'd0);
        check("t6_rst_inflight",  64'(inflight),   64'd0);
        check("t6_rst_err",       64'(err_orphan), 64'd0);
        clear_lanes();
        tick();
        tick();
        rst_n = 1'b1;
        run(2);
        check("t6_post_inflight", 64'(inflight), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
